// File: rtl/led_band_fc_chain_setter.sv
// led_band_fc_chain_setter
// Function-control programmer for a daisy-chain of N_DRIVERS LED drivers.
// Per-driver FC words are staged in a shadow bank over a simple write port.
// When the sync module issues a FCWRTEN latch command, the shadow bank is
// copied into the active bank. The active bank is then shifted out on SOUT,
// farthest driver first and MSB first, one bit per SCLK rise. A following
// WRTFC latch command either completes the sequence (done) or, if bits are
// still outstanding, aborts it (err).
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   SCLK, LAT           driver shift clock / latch line, sampled on clk
//   w_addr/w_data/w_enable  shadow-bank write (out-of-range addr ignored)
//   SOUT                serial FC data to the chain
//   en                  1 = normal data path owns SOUT, 0 = FC shift active
//   busy                FSM not idle
//   done / err          one-clk pulses: sequence complete / early WRTFC
//   pending             shadow holds writes not yet loaded into active
//
// Optional build macro LED_BAND_FC_STATUS_EN adds:
//   r_addr/r_data       registered read of an active word (1-clk latency)
//   err_cnt             saturating count of err pulses
//
// States:
//   state | meaning
//   IDLE  | normal data path owns SOUT, waiting for FCWRTEN
//   SHIFT | shifting active bank out, one bit per SCLK rise with LAT low
//   WAIT  | all bits shifted, SOUT holds bit 0, waiting for WRTFC
module led_band_fc_chain_setter #(
  parameter int FC_WIDTH      = 48,
  parameter int N_DRIVERS     = 4,
  parameter int FCWRTEN_SCLKS = 15,
  parameter int WRTFC_SCLKS   = 5,
  localparam int AW = (N_DRIVERS > 1) ? $clog2(N_DRIVERS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SCLK,
  input  logic                LAT,
  input  logic [AW-1:0]       w_addr,
  input  logic [FC_WIDTH-1:0] w_data,
  input  logic                w_enable,
  output logic                SOUT,
  output logic                en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                pending
`ifdef LED_BAND_FC_STATUS_EN
  ,
  input  logic [AW-1:0]       r_addr,
  output logic [FC_WIDTH-1:0] r_data,
  output logic [7:0]          err_cnt
`endif
);

  localparam int TOTAL_BITS = N_DRIVERS * FC_WIDTH;
  localparam int BW         = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam int CMD_MAX    = (FCWRTEN_SCLKS > WRTFC_SCLKS) ? FCWRTEN_SCLKS : WRTFC_SCLKS;
  localparam int LCW        = $clog2(CMD_MAX + 2);
  localparam logic [BW-1:0] BIDX_TOP = BW'(TOTAL_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sclk_q, lat_q;
  logic [LCW-1:0]        lat_cnt_q, lat_cnt_d;
  logic [BW-1:0]         bidx_q, bidx_d;
  logic [FC_WIDTH-1:0]   shadow_q [N_DRIVERS];
  logic [FC_WIDTH-1:0]   shadow_d [N_DRIVERS];
  logic [TOTAL_BITS-1:0] active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  sout_q, sout_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic posedge_sclk, lat_fall, ev_fcwrten, ev_wrtfc, shift_edge, load, wr_ok;

  assign posedge_sclk = SCLK & ~sclk_q;
  assign lat_fall     = lat_q & ~LAT;
  // lat_cnt_q still holds the full count on the falling-edge clk; it clears after.
  assign ev_fcwrten   = lat_fall && (lat_cnt_q == LCW'(FCWRTEN_SCLKS));
  assign ev_wrtfc     = lat_fall && (lat_cnt_q == LCW'(WRTFC_SCLKS));
  assign shift_edge   = posedge_sclk & ~LAT;
  assign wr_ok        = w_enable && (32'(w_addr) < N_DRIVERS);

  always_comb begin
    lat_cnt_d = '0;
    if (LAT) begin
      lat_cnt_d = lat_cnt_q;
      if (posedge_sclk && (lat_cnt_q != '1)) lat_cnt_d = lat_cnt_q + LCW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    bidx_d    = bidx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load      = 1'b0;

    // LAT events take priority over SCLK shifting.
    case (state_q)
      IDLE: begin
        if (ev_fcwrten) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ev_wrtfc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (ev_fcwrten) begin
          load = 1'b1;
        end else if (shift_edge) begin
          if (bidx_q == '0) state_d = WAIT;
          else              bidx_d  = bidx_q - BW'(1);
        end
      end
      WAIT: begin
        if (ev_wrtfc) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (ev_fcwrten) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load copies the pre-write shadow; a same-cycle write survives in shadow
    // and keeps pending set.
    if (load) begin
      for (int d = 0; d < N_DRIVERS; d++) active_d[d*FC_WIDTH +: FC_WIDTH] = shadow_q[d];
      bidx_d    = BIDX_TOP;
      pending_d = 1'b0;
    end
    if (wr_ok) begin
      shadow_d[w_addr] = w_data;
      pending_d        = 1'b1;
    end

    sout_d = (state_q == IDLE) ? 1'b0 : active_q[bidx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sclk_q    <= 1'b0;
      lat_q     <= 1'b0;
      lat_cnt_q <= '0;
      bidx_q    <= '0;
      active_q  <= '0;
      for (int d = 0; d < N_DRIVERS; d++) shadow_q[d] <= '0;
      pending_q <= 1'b0;
      sout_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= SCLK;
      lat_q     <= LAT;
      lat_cnt_q <= lat_cnt_d;
      bidx_q    <= bidx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      sout_q    <= sout_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign SOUT    = sout_q;
  assign en      = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign pending = pending_q;

`ifdef LED_BAND_FC_STATUS_EN
  logic [FC_WIDTH-1:0] r_data_q, r_data_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  always_comb begin
    r_data_d = '0;
    for (int d = 0; d < N_DRIVERS; d++)
      if (r_addr == AW'(d)) r_data_d = active_q[d*FC_WIDTH +: FC_WIDTH];
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      r_data_q  <= r_data_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign r_data  = r_data_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_led_band_fc_chain_setter.sv
// Self-checking bench for led_band_fc_chain_setter (default parameters).
module tb_led_band_fc_chain_setter;

  localparam int FCW = 48;
  localparam int ND  = 4;
  localparam int NB  = FCW * ND;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SCLK = 1'b0;
  logic          LAT = 1'b0;
  logic [1:0]    w_addr = '0;
  logic [FCW-1:0] w_data = '0;
  logic          w_enable = 1'b0;
  logic          SOUT, en, busy, done, err, pending;

  led_band_fc_chain_setter dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .LAT(LAT),
    .w_addr(w_addr), .w_data(w_data), .w_enable(w_enable),
    .SOUT(SOUT), .en(en), .busy(busy), .done(done), .err(err), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_err = 0;
  int en_bad = 0;

  // Reference model: what the driver chain should receive.
  logic [FCW-1:0] m_sh  [ND];
  logic [FCW-1:0] m_act [ND];
  bit got [$];

  typedef struct {
    int   sclks;
    logic exp_busy;
    int   exp_err;
    int   exp_done;
  } cmd_vec_t;
  cmd_vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_err++;
  endtask

  task automatic wr(input int a, input logic [FCW-1:0] d);
    w_addr = 2'(a); w_data = d; w_enable = 1'b1;
    step();
    w_enable = 1'b0;
    m_sh[a] = d;
  endtask

  task automatic sclk_pulse(input bit capture);
    if (capture) begin
      got.push_back(SOUT);
      if (en !== 1'b0) en_bad++;
    end
    SCLK = 1'b1; step(); step();
    SCLK = 1'b0; step(); step();
  endtask

  task automatic lat_cmd(input int n);
    LAT = 1'b1; step(); step();
    repeat (n) sclk_pulse(1'b0);
    step();
    LAT = 1'b0; step(); step(); step();
    if (n == 15) begin
      for (int d = 0; d < ND; d++) m_act[d] = m_sh[d];
    end
  endtask

  task automatic shift_run(input int nbits, input int wr_at, input int wa, input logic [FCW-1:0] wd);
    got.delete();
    en_bad = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i == wr_at) wr(wa, wd);
      sclk_pulse(1'b1);
    end
  endtask

  // Expected stream: farthest driver first, each word MSB first.
  task automatic check_stream(input string name, input int nbits);
    bit exp [$];
    int miss = 0;
    int first = -1;
    for (int d = ND - 1; d >= 0; d--)
      for (int b = FCW - 1; b >= 0; b--) exp.push_back(m_act[d][b]);
    for (int i = 0; i < nbits; i++)
      if (got[i] != exp[i]) begin
        miss++;
        if (first < 0) first = i;
      end
    if (miss != 0) $display("  first stream difference at bit %0d", first);
    chk(name, 64'(miss), 64'd0);
    chk({name, "_en_low"}, 64'(en_bad), 64'd0);
  endtask

  initial begin
    int bad_rst = 0;
    int e0, d0;
    logic [63:0] r64;
    for (int d = 0; d < ND; d++) begin m_sh[d] = '0; m_act[d] = '0; end

    // Reset held with activity on SCLK/LAT.
    for (int i = 0; i < 24; i++) begin
      SCLK = (i % 4) < 2;
      LAT  = (i % 8) < 4;
      step();
      if (en !== 1'b1 || busy !== 1'b0 || SOUT !== 1'b0 || pending !== 1'b0 ||
          done !== 1'b0 || err !== 1'b0) bad_rst++;
    end
    chk("reset_hold", 64'(bad_rst), 64'd0);
    SCLK = 1'b0; LAT = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    chk("rst_en", 64'(en), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_sout", 64'(SOUT), 64'd0);

    // Command decode table, applied back to back.
    tbl[0] = '{7,  1'b0, 0, 0};
    tbl[1] = '{40, 1'b0, 0, 0};
    tbl[2] = '{14, 1'b0, 0, 0};
    tbl[3] = '{5,  1'b0, 0, 0};
    tbl[4] = '{15, 1'b1, 0, 0};
    tbl[5] = '{16, 1'b1, 0, 0};
    tbl[6] = '{5,  1'b0, 1, 0};
    tbl[7] = '{15, 1'b1, 0, 0};
    tbl[8] = '{15, 1'b1, 0, 0};
    tbl[9] = '{5,  1'b0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      e0 = n_err; d0 = n_done;
      lat_cmd(tbl[i].sclks);
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_en", i), 64'(en), 64'(!tbl[i].exp_busy));
      chk($sformatf("tbl%0d_err", i), 64'(n_err - e0), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_done", i), 64'(n_done - d0), 64'(tbl[i].exp_done));
    end

    // Full sequence with the fixed words.
    wr(3, 48'hA5A5_0000_FFFF);
    wr(2, 48'h1);
    wr(1, 48'h8000_0000_0000);
    wr(0, 48'h0123_4567_89AB);
    chk("full_pending_set", 64'(pending), 64'd1);
    lat_cmd(15);
    chk("full_pending_clr", 64'(pending), 64'd0);
    chk("full_en_low", 64'(en), 64'd0);
    shift_run(NB, -1, 0, '0);
    check_stream("full_stream", NB);
    e0 = n_err; d0 = n_done;
    lat_cmd(5);
    chk("full_done", 64'(n_done - d0), 64'd1);
    chk("full_no_err", 64'(n_err - e0), 64'd0);
    chk("full_en_back", 64'(en), 64'd1);

    // Short sequence: WRTFC before all bits are out.
    lat_cmd(15);
    shift_run(100, -1, 0, '0);
    check_stream("short_stream", 100);
    e0 = n_err; d0 = n_done;
    lat_cmd(5);
    chk("short_err", 64'(n_err - e0), 64'd1);
    chk("short_no_done", 64'(n_done - d0), 64'd0);
    chk("short_idle", 64'(busy), 64'd0);
    chk("short_en", 64'(en), 64'd1);

    // Mid-shift write does not disturb the stream; restart picks it up.
    lat_cmd(15);
    shift_run(NB, 50, 1, 48'hFFFF_FFFF_FFFF);
    check_stream("midwr_stream", NB);
    chk("midwr_pending", 64'(pending), 64'd1);
    lat_cmd(15);
    chk("restart_busy", 64'(busy), 64'd1);
    shift_run(NB, -1, 0, '0);
    check_stream("restart_stream", NB);
    d0 = n_done;
    lat_cmd(5);
    chk("restart_done", 64'(n_done - d0), 64'd1);

    // Randomized words and write orders.
    for (int it = 0; it < 3; it++) begin
      int nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        r64 = {$urandom, $urandom};
        wr($urandom_range(0, ND - 1), r64[FCW-1:0]);
      end
      lat_cmd(15);
      shift_run(NB, -1, 0, '0);
      check_stream($sformatf("rand%0d_stream", it), NB);
      d0 = n_done;
      lat_cmd(5);
      chk($sformatf("rand%0d_done", it), 64'(n_done - d0), 64'd1);
    end

    // Asynchronous reset mid-shift.
    lat_cmd(15);
    shift_run(120, -1, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 64'(en), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    step(); step();
    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin m_sh[d] = '0; m_act[d] = '0; end
    step();
    chk("arst_pending", 64'(pending), 64'd0);
    lat_cmd(15);
    shift_run(NB, -1, 0, '0);
    check_stream("arst_zero_stream", NB);
    d0 = n_done;
    lat_cmd(5);
    chk("arst_done", 64'(n_done - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
